// File: rtl/uart_defs.sv
// Shared encodings for the fifo_8 UART transmitter.
// ST_PARITY exists only when UART_TX_PARITY_EN is defined.
package uart_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd6;
`endif

  localparam logic [1:0] STATUS_EMPTY = 2'b00;
  localparam logic       TX_IDLE      = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: tick pulses on the last cycle of every DIV-cycle period,
// with the period re-aligned to zero while restart is held.
module baud_gen #(
  parameter int DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains fifo_8 one byte per frame and sends it as 8N1/8N2 UART, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1/8E2).
module fifo_uart_tx
  import uart_defs::*;
#(
  parameter int DIV       = 104,
  parameter int RD_LAT    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic [1:0] status,
  output logic       cke_o,
  output logic       tx,
  output logic       busy
);

  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  logic [2:0] state;
  logic [7:0] shifter;
  logic [2:0] bit_cnt;
  logic [1:0] wait_cnt;
  logic       stop_cnt;
  logic       tx_q;
  logic       baud_tick;
  logic       restart;
  logic       data_avail;
  logic       load;
`ifdef UART_TX_PARITY_EN
  logic       par_q;
`endif

  assign data_avail = (status != STATUS_EMPTY);

  // Baud phase is pinned to zero until the start bit begins, so every frame is exact.
  assign restart = (state == ST_IDLE) || (state == ST_REQ) || (state == ST_WAIT);

  assign load = ((state == ST_REQ) && (RD_LAT == 0)) ||
                ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));

  baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_q     <= TX_IDLE;
      shifter  <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else if (load) begin
      shifter <= data;
      tx_q    <= 1'b0;
      state   <= ST_START;
`ifdef UART_TX_PARITY_EN
      par_q   <= ^data;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= TX_IDLE;
          if (data_avail) state <= ST_REQ;
        end
        ST_REQ: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
        end
        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx_q    <= shifter[0];
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= ST_PARITY;
              tx_q     <= par_q;
`else
              state    <= ST_STOP;
              tx_q     <= 1'b1;
              stop_cnt <= 1'b0;
`endif
            end else begin
              tx_q    <= shifter[1];
              shifter <= {1'b0, shifter[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            state    <= ST_STOP;
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
`endif
        ST_STOP: begin
          // Status is re-checked only here, so a waiting byte follows with no idle bit.
          if (baud_tick) begin
            if (stop_cnt == STOP_LAST) begin
              state <= data_avail ? ST_REQ : ST_IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_q  <= TX_IDLE;
        end
      endcase
    end
  end

  assign cke_o = (state == ST_REQ);
  assign busy  = (state != ST_IDLE);
  assign tx    = tx_q;

endmodule
